// File: rtl/gpr_file_if.sv
// Operand-read, writeback and issue signals between the pipeline and the GPR file.
// The pipeline side uses the master modport and the register file uses the slave modport.
interface gpr_file_if #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [ISA_WIDTH-1:0]      src1;
  logic [ISA_WIDTH-1:0]      src2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [ISA_WIDTH-1:0]      srd;
  logic                      gpr_w_en;
  logic                      issue_valid;
  logic                      issue_long;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic                      stall;
  logic [REG_ADDR_WIDTH:0]   busy_cnt;

  modport master (
    output rs1, rs2, rd, srd, gpr_w_en, issue_valid, issue_long, issue_rd,
    input  src1, src2, stall, busy_cnt
  );

  modport slave (
    input  rs1, rs2, rd, srd, gpr_w_en, issue_valid, issue_long, issue_rd,
    output src1, src2, stall, busy_cnt
  );
endinterface

// File: rtl/gpr_file.sv
// GPR file with same-cycle writeback bypass and a busy-bit scoreboard for long-latency results.
// The stall output is raised when an issuing instruction reads a register whose result is still pending.
module gpr_file #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  gpr_file_if.slave  bus
);
  localparam int N  = 1 << REG_ADDR_WIDTH;
  localparam int CW = REG_ADDR_WIDTH + 1;

  logic [ISA_WIDTH-1:0] r_regs [1:N-1];
  logic [N-1:0]         r_busy;
  logic [CW-1:0]        r_busy_cnt;

  logic          w_wr;
  logic          w_set;
  logic          w_haz1;
  logic          w_haz2;
  logic          w_stall;
  logic          w_inc;
  logic          w_dec;
  logic [N-1:0]  w_busy_nxt;

  // Writeback to an operand hides its busy bit because the bypass supplies the value.
  always_comb begin
    w_haz1 = (bus.rs1 != '0) && r_busy[bus.rs1] && !(bus.gpr_w_en && (bus.rd == bus.rs1));
    w_haz2 = (bus.rs2 != '0) && r_busy[bus.rs2] && !(bus.gpr_w_en && (bus.rd == bus.rs2));
    w_stall = bus.issue_valid && (w_haz1 || w_haz2);
  end

  always_comb begin
    w_wr  = bus.gpr_w_en && (bus.rd != '0);
    w_set = bus.issue_valid && bus.issue_long && (bus.issue_rd != '0) && !w_stall;
    w_busy_nxt = r_busy;
    if (w_wr)
      w_busy_nxt[bus.rd] = 1'b0;
    if (w_set)
      w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_inc = w_set && !r_busy[bus.issue_rd];
    w_dec = w_wr && r_busy[bus.rd] && !(w_set && (bus.issue_rd == bus.rd));
  end

  always_comb begin
    if (bus.rs1 == '0)
      bus.src1 = '0;
    else if (bus.gpr_w_en && (bus.rd == bus.rs1))
      bus.src1 = bus.srd;
    else
      bus.src1 = r_regs[bus.rs1];

    if (bus.rs2 == '0)
      bus.src2 = '0;
    else if (bus.gpr_w_en && (bus.rd == bus.rs2))
      bus.src2 = bus.srd;
    else
      bus.src2 = r_regs[bus.rs2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < N; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.rd] <= bus.srd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= r_busy_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign bus.stall    = w_stall;
  assign bus.busy_cnt = r_busy_cnt;
endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, write/read, x0, bypass, load-use stall,
// simultaneous set/clear, stalled-issue, WAW and asynchronous reset mid-operation.
module tb_gpr_file;
  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  gpr_file_if #(.ISA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  gpr_file #(.ISA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after a rising edge, leaving room to drive and sample mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.srd = '0; bus.gpr_w_en = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_rd = '0;
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    idle();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", 32'(bus.busy_cnt), 32'd0);
    // Bypass stays live during reset, but the write itself is discarded.
    bus.gpr_w_en = 1'b1; bus.rd = 5'd5; bus.srd = 32'h77; bus.rs1 = 5'd5;
    #1;
    chk("rst_bypass", bus.src1, 32'h77);
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd8;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.rs1 = 5'(i);
      bus.rs2 = 5'(31 - i);
      #1;
      chk("reset_src1", bus.src1, 32'd0);
      chk("reset_src2", bus.src2, 32'd0);
    end
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_cnt", 32'(bus.busy_cnt), 32'd0);

    // Write and read back.
    idle();
    bus.gpr_w_en = 1'b1; bus.rd = 5'd5; bus.srd = 32'hDEADBEEF;
    tick();
    idle(); bus.rs1 = 5'd5;
    #1;
    chk("wr_rd5", bus.src1, 32'hDEADBEEF);

    // Writes to x0 are discarded, including the bypass path.
    bus.gpr_w_en = 1'b1; bus.rd = 5'd0; bus.srd = 32'h1234; bus.rs2 = 5'd0;
    #1;
    chk("x0_bypass", bus.src2, 32'd0);
    tick();
    idle();
    #1;
    chk("x0_read", bus.src2, 32'd0);

    // Bypass on register 7.
    bus.gpr_w_en = 1'b1; bus.rd = 5'd7; bus.srd = 32'h11;
    tick();
    bus.srd = 32'h22; bus.rs1 = 5'd7;
    #1;
    chk("bypass_same", bus.src1, 32'h22);
    tick();
    idle(); bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    #1;
    chk("bypass_after1", bus.src1, 32'h22);
    chk("bypass_after2", bus.src2, 32'h22);

    // Load-use stall on register 3.
    idle();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
    #1;
    chk("lu_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    chk("lu_cnt1", 32'(bus.busy_cnt), 32'd1);
    bus.issue_valid = 1'b1; bus.rs2 = 5'd3;
    #1;
    chk("lu_stall_a", 32'(bus.stall), 32'd1);
    tick();
    chk("lu_stall_b", 32'(bus.stall), 32'd1);
    tick();
    chk("lu_stall_c", 32'(bus.stall), 32'd1);
    bus.gpr_w_en = 1'b1; bus.rd = 5'd3; bus.srd = 32'h55;
    #1;
    chk("lu_wb_stall", 32'(bus.stall), 32'd0);
    chk("lu_wb_src2", bus.src2, 32'h55);
    tick();
    idle();
    #1;
    chk("lu_cnt0", 32'(bus.busy_cnt), 32'd0);

    // Simultaneous set and clear on the same index: set wins.
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd9;
    tick();
    chk("sc_cnt_pre", 32'(bus.busy_cnt), 32'd1);
    bus.gpr_w_en = 1'b1; bus.rd = 5'd9; bus.srd = 32'h99;
    #1;
    chk("sc_same_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    chk("sc_same_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.issue_valid = 1'b1; bus.rs1 = 5'd9;
    #1;
    chk("sc_busy9", 32'(bus.stall), 32'd1);

    // Clear 9 and set 10 in the same cycle.
    idle();
    bus.gpr_w_en = 1'b1; bus.rd = 5'd9; bus.srd = 32'h9A;
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd10;
    tick();
    idle();
    #1;
    chk("sc_diff_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.issue_valid = 1'b1; bus.rs1 = 5'd10;
    #1;
    chk("sc_busy10", 32'(bus.stall), 32'd1);
    bus.rs1 = 5'd9;
    #1;
    chk("sc_free9", 32'(bus.stall), 32'd0);

    // Clearing a non-busy index does not decrement.
    idle();
    bus.gpr_w_en = 1'b1; bus.rd = 5'd20; bus.srd = 32'h20;
    tick();
    idle();
    #1;
    chk("nonbusy_clr_cnt", 32'(bus.busy_cnt), 32'd1);

    // A stalled long issue leaves the scoreboard untouched.
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd11; bus.rs1 = 5'd10;
    #1;
    chk("stalled_stall", 32'(bus.stall), 32'd1);
    tick();
    idle();
    #1;
    chk("stalled_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.issue_valid = 1'b1; bus.rs2 = 5'd11;
    #1;
    chk("stalled_free11", 32'(bus.stall), 32'd0);

    // WAW: long issue to already-busy 10 keeps count and raises no stall.
    idle();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd10;
    #1;
    chk("waw_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    chk("waw_cnt", 32'(bus.busy_cnt), 32'd1);
    bus.gpr_w_en = 1'b1; bus.rd = 5'd10; bus.srd = 32'h10;
    tick();
    idle();
    #1;
    chk("clr10_cnt", 32'(bus.busy_cnt), 32'd0);

    // Reset mid-operation.
    bus.gpr_w_en = 1'b1; bus.rd = 5'd4; bus.srd = 32'hAA;
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd4;
    tick();
    bus.issue_rd = 5'd6;
    tick();
    idle(); bus.rs1 = 5'd4;
    #1;
    chk("mid_cnt2", 32'(bus.busy_cnt), 32'd2);
    chk("mid_src1", bus.src1, 32'hAA);
    rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("mid_rst_src1", bus.src1, 32'd0);
    bus.issue_valid = 1'b1; bus.rs2 = 5'd6;
    #1;
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_post_stall", 32'(bus.stall), 32'd0);
    chk("mid_post_cnt", 32'(bus.busy_cnt), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
